// File: rtl/alu_exec_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_pkg
// Shared definitions for the execute/writeback stage: default parameter values,
// the opcode encoding seen on the decode interface, and the stage FSM encoding.
// -----------------------------------------------------------------------------
package alu_exec_stage_pkg;

    localparam int SRCSIZE_DEF  = 2;  // 2^SRCSIZE registers in the file
    localparam int WIDTH_DEF    = 8;  // matches the register file data port
    localparam int ZERO_REG_DEF = 3;  // hard-zero register index

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_LI  = 3'd6,
        OP_MUL = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

    // Only the two arithmetic ops produce a meaningful carry/borrow.
    function automatic logic updates_carry(input opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_exec_stage_shift_add_mul.sv
// -----------------------------------------------------------------------------
// shift_add_mul
// Iterative shift-add multiplier returning the low WIDTH bits of a*b.
// A start pulse loads the operands; the unit then runs exactly WIDTH cycles.
// done is asserted combinationally during the last iteration, and product is
// valid in that same cycle, so the caller can register the result on the edge
// that ends the final iteration.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load a/b and begin (ignored while busy)
//   a, b            multiplicand / multiplier
//   busy            iteration in progress
//   done            final iteration cycle; product valid
//   product         low WIDTH bits of a*b (valid while done)
// -----------------------------------------------------------------------------
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic [WIDTH-1:0] acc_next;

    // The multiplicand is shifted within WIDTH bits, so bits above the low
    // half fall off naturally and the accumulator wraps modulo 2^WIDTH.
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign busy    = busy_q;
    assign done    = busy_q && (count_q == LAST);
    assign product = acc_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else if (start && !busy_q) begin
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            count_q  <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// Execute/writeback stage in front of the register file. One instruction is
// accepted per handshake, walks IDLE->READ->EXEC->WB, and retires with a single
// registered write/done pulse. Writes to ZERO_REG are suppressed.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr_valid/ready   decode handshake (ready only in IDLE)
//   opcode,rs1,rs2,rd   decoded instruction fields; imm for LI
//   src1, src2          register file read selects (held from accept to IDLE)
//   regA, regB          register file combinational read data
//   dst, data, write    register file write port (write pulses in WB)
//   done                retire pulse, with or without a write
//   flag_z, flag_c      zero flag of last retire; carry/borrow of last ADD/SUB
// -----------------------------------------------------------------------------
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int SRCSIZE  = SRCSIZE_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [2:0]         opcode,
    input  logic [SRCSIZE-1:0] rs1,
    input  logic [SRCSIZE-1:0] rs2,
    input  logic [SRCSIZE-1:0] rd,
    input  logic [WIDTH-1:0]   imm,
    output logic [SRCSIZE-1:0] src1,
    output logic [SRCSIZE-1:0] src2,
    input  logic [WIDTH-1:0]   regA,
    input  logic [WIDTH-1:0]   regB,
    output logic [SRCSIZE-1:0] dst,
    output logic [WIDTH-1:0]   data,
    output logic               write,
    output logic               done,
    output logic               flag_z,
    output logic               flag_c
);

    state_e             state_q;
    state_e             state_next;

    opcode_e            op_q;
    logic [SRCSIZE-1:0] rd_q;
    logic [WIDTH-1:0]   imm_q;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;

    logic               accept;
    logic               retire;
    logic [WIDTH-1:0]   exec_result;
    logic               exec_carry;
    logic [WIDTH:0]     wide;

    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [WIDTH-1:0]   mul_product;

    assign instr_ready = (state_q == S_IDLE);
    assign accept      = instr_valid && instr_ready;

    // Single-cycle ops finish in their first EXEC cycle; MUL waits for the
    // multiplier's final iteration.
    assign retire = (state_q == S_EXEC) && ((op_q != OP_MUL) || mul_done);

    // The multiplier loads straight from the read ports during READ so its
    // WIDTH iterations line up exactly with the EXEC cycles.
    assign mul_start = (state_q == S_READ) && (op_q == OP_MUL) && !mul_busy;

    shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (regA),
        .b       (regB),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        state_next = state_q;
        unique case (state_q)
            S_IDLE: if (instr_valid) state_next = S_READ;
            S_READ: state_next = S_EXEC;
            S_EXEC: if (retire) state_next = S_WB;
            S_WB:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- ALU
    always_comb begin
        exec_result = '0;
        exec_carry  = 1'b0;
        wide        = '0;
        unique case (op_q)
            OP_ADD: begin
                wide        = {1'b0, op_a} + {1'b0, op_b};
                exec_result = wide[WIDTH-1:0];
                exec_carry  = wide[WIDTH];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow, i.e. a < b.
                wide        = {1'b0, op_a} - {1'b0, op_b};
                exec_result = wide[WIDTH-1:0];
                exec_carry  = wide[WIDTH];
            end
            OP_AND:  exec_result = op_a & op_b;
            OP_OR:   exec_result = op_a | op_b;
            OP_XOR:  exec_result = op_a ^ op_b;
            OP_SHL:  exec_result = op_a << op_b[2:0];
            OP_LI:   exec_result = imm_q;
            OP_MUL:  exec_result = mul_product;
            default: exec_result = '0;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_ADD;
            rd_q   <= '0;
            imm_q  <= '0;
            src1   <= '0;
            src2   <= '0;
            op_a   <= '0;
            op_b   <= '0;
            dst    <= '0;
            data   <= '0;
            write  <= 1'b0;
            done   <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            write <= 1'b0;
            done  <= 1'b0;

            if (accept) begin
                op_q  <= opcode_e'(opcode);
                rd_q  <= rd;
                imm_q <= imm;
                src1  <= rs1;
                src2  <= rs2;
            end

            if (state_q == S_READ) begin
                op_a <= regA;
                op_b <= regB;
            end

            // Registering the write port here makes write/done high for
            // exactly the WB cycle.
            if (retire) begin
                dst    <= rd_q;
                data   <= exec_result;
                write  <= (rd_q != SRCSIZE'(ZERO_REG));
                done   <= 1'b1;
                flag_z <= (exec_result == '0);
                if (updates_carry(op_q)) begin
                    flag_c <= exec_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
// Drives decoded instructions into alu_exec_stage, models the register file it
// writes, and scoreboards every retire against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

    localparam logic [2:0] T_ADD = 3'd0;
    localparam logic [2:0] T_SUB = 3'd1;
    localparam logic [2:0] T_AND = 3'd2;
    localparam logic [2:0] T_OR  = 3'd3;
    localparam logic [2:0] T_XOR = 3'd4;
    localparam logic [2:0] T_SHL = 3'd5;
    localparam logic [2:0] T_LI  = 3'd6;
    localparam logic [2:0] T_MUL = 3'd7;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] opcode;
    logic [1:0] rs1, rs2, rd;
    logic [7:0] imm;
    logic [1:0] src1, src2;
    logic [7:0] regA, regB;
    logic [1:0] dst;
    logic [7:0] data;
    logic       write;
    logic       done;
    logic       flag_z;
    logic       flag_c;

    alu_exec_stage dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .imm         (imm),
        .src1        (src1),
        .src2        (src2),
        .regA        (regA),
        .regB        (regB),
        .dst         (dst),
        .data        (data),
        .write       (write),
        .done        (done),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file written only by the DUT (or the preset during reset).
    logic [7:0] rf [4];
    logic       preset_en;
    assign regA = rf[src1];
    assign regB = rf[src2];
    always @(posedge clk) begin
        if (preset_en) begin
            rf[0] <= 8'd5;
            rf[1] <= 8'd7;
            rf[2] <= 8'd0;
            rf[3] <= 8'd0;
        end else if (write) begin
            rf[dst] <= data;
        end
    end

    // ---------------------------------------------------------------- checking
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] dst;
        logic [7:0] data;
        logic       wr;
        logic       z;
        logic       c;
        int         due;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Monitor: every retire must match the oldest outstanding expectation,
    // and must appear in the cycle the expectation predicts.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_cycle"},  32'(cyc),    32'(mon_e.due));
                    check({mon_e.name, "_dst"},    32'(dst),    32'(mon_e.dst));
                    check({mon_e.name, "_data"},   32'(data),   32'(mon_e.data));
                    check({mon_e.name, "_write"},  32'(write),  32'(mon_e.wr));
                    check({mon_e.name, "_flag_z"}, 32'(flag_z), 32'(mon_e.z));
                    check({mon_e.name, "_flag_c"}, 32'(flag_c), 32'(mon_e.c));
                end
            end else if (write) begin
                check("write_without_done", 32'(write), 32'd0);
            end
        end
    end

    // ---------------------------------------------------------------- model
    int   m_rf [4];
    logic m_z;
    logic m_c;
    int   last_acc = 0;
    int   last_lat = 0;
    bit   chained  = 1'b0;

    // Called at a negedge. Presents the instruction, waits for the accepting
    // edge, predicts the retire, and leaves instr_valid high if hold is set.
    task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] d, input logic [7:0] im, input bit hold,
                         input string nm);
        int   t;
        int   va, vb, res, lat;
        logic c;
        exp_t e;
        opcode = op; rs1 = a; rs2 = b; rd = d; imm = im;
        instr_valid = 1'b1;
        t = 0;
        while (!instr_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!instr_ready) begin
            check({nm, "_accept_timeout"}, 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            chained = 1'b0;
            return;
        end
        va = m_rf[a];
        vb = m_rf[b];
        c  = m_c;
        case (op)
            T_ADD: begin res = va + vb; c = (res > 255); res = res % 256; end
            T_SUB: begin c = (va < vb); res = (va - vb + 256) % 256; end
            T_AND: res = va & vb;
            T_OR:  res = va | vb;
            T_XOR: res = va ^ vb;
            T_SHL: res = (va << (vb % 8)) % 256;
            T_LI:  res = int'(im);
            default: res = (va * vb) % 256;
        endcase
        lat = (op == T_MUL) ? 9 : 2;
        m_z = (res == 0);
        m_c = c;
        e.dst  = d;
        e.data = res[7:0];
        e.wr   = (d != 2'd3);
        e.z    = m_z;
        e.c    = m_c;
        e.due  = cyc + 1 + lat;
        e.name = nm;
        if (e.wr) m_rf[d] = res;
        if (chained) check({nm, "_accept_spacing"}, 32'(cyc + 1 - last_acc), 32'(last_lat + 2));
        last_acc = cyc + 1;
        last_lat = lat;
        sb.push_back(e);
        @(negedge clk);
        chained = hold;
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_drain"}, 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int t;
        rst = 1'b1; preset_en = 1'b1;
        instr_valid = 1'b0; opcode = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
        m_rf[0] = 5; m_rf[1] = 7; m_rf[2] = 0; m_rf[3] = 0;
        m_z = 1'b0; m_c = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_instr_ready", 32'(instr_ready), 32'd1);
        check("rst_write",       32'(write),       32'd0);
        check("rst_done",        32'(done),        32'd0);
        check("rst_flag_z",      32'(flag_z),      32'd0);
        check("rst_flag_c",      32'(flag_c),      32'd0);
        check("rst_src",         32'({src1, src2}), 32'd0);
        check("rst_dst_data",    32'({dst, data}),  32'd0);
        rst = 1'b0; preset_en = 1'b0;
        @(negedge clk);

        // r0=5, r1=7 -> 12 into r2.
        issue(T_ADD, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, "add_5_7");
        check("add_5_7_ready_n1", 32'(instr_ready), 32'd0);
        @(negedge clk);
        check("add_5_7_ready_n2", 32'(instr_ready), 32'd0);
        drain("add_5_7");
        check("add_5_7_r2", 32'(rf[2]), 32'd12);

        issue(T_LI,  2'd0, 2'd0, 2'd0, 8'hF0, 1'b0, "li_f0");
        issue(T_LI,  2'd0, 2'd0, 2'd1, 8'h20, 1'b0, "li_20");
        issue(T_ADD, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, "add_carry");
        drain("add_carry");
        check("add_carry_r2", 32'(rf[2]), 32'h10);
        check("add_carry_c",  32'(flag_c), 32'd1);

        issue(T_LI,  2'd0, 2'd0, 2'd0, 8'd5, 1'b0, "li_5");
        issue(T_LI,  2'd0, 2'd0, 2'd1, 8'd7, 1'b0, "li_7");
        issue(T_SUB, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, "sub_borrow");
        drain("sub_borrow");
        check("sub_borrow_r2", 32'(rf[2]), 32'hFE);
        issue(T_SUB, 2'd1, 2'd1, 2'd2, 8'h00, 1'b0, "sub_zero");
        drain("sub_zero");
        check("sub_zero_z", 32'(flag_z), 32'd1);
        check("sub_zero_c", 32'(flag_c), 32'd0);

        issue(T_LI,  2'd0, 2'd0, 2'd0, 8'd13, 1'b0, "li_13");
        issue(T_LI,  2'd0, 2'd0, 2'd1, 8'd11, 1'b0, "li_11");
        issue(T_MUL, 2'd0, 2'd1, 2'd1, 8'h00, 1'b0, "mul_13_11");
        drain("mul_13_11");
        check("mul_13_11_r1", 32'(rf[1]), 32'h8F);
        issue(T_LI,  2'd0, 2'd0, 2'd0, 8'd20, 1'b0, "li_20d");
        issue(T_MUL, 2'd0, 2'd0, 2'd2, 8'h00, 1'b0, "mul_wrap");
        drain("mul_wrap");
        check("mul_wrap_r2", 32'(rf[2]), 32'h90);

        issue(T_LI, 2'd0, 2'd0, 2'd3, 8'hAA, 1'b0, "li_zero_reg");
        drain("li_zero_reg");
        check("li_zero_reg_r3", 32'(rf[3]), 32'd0);

        // Abort a MUL with reset in its fourth EXEC cycle; nothing may retire.
        opcode = T_MUL; rs1 = 2'd0; rs2 = 2'd1; rd = 2'd2; imm = '0;
        instr_valid = 1'b1;
        t = 0;
        while (!instr_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("abort_accept", 32'(instr_ready), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready",  32'(instr_ready), 32'd1);
        check("abort_write",  32'(write),       32'd0);
        check("abort_done",   32'(done),        32'd0);
        check("abort_flags",  32'({flag_z, flag_c}), 32'd0);
        rst = 1'b0;
        m_z = 1'b0; m_c = 1'b0; chained = 1'b0;
        repeat (12) @(negedge clk);
        issue(T_ADD, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, "post_abort_add");
        drain("post_abort_add");

        // instr_valid held across LI then ADD: second reads the first's write.
        issue(T_LI,  2'd0, 2'd0, 2'd0, 8'h33, 1'b1, "b2b_li");
        issue(T_ADD, 2'd0, 2'd0, 2'd2, 8'h00, 1'b0, "b2b_add");
        drain("b2b_add");
        check("b2b_add_r2", 32'(rf[2]), 32'h66);

        // Randomised mix, sometimes held back-to-back, sometimes with gaps.
        for (int i = 0; i < 150; i++) begin
            logic [2:0] op;
            logic [1:0] a, b, d;
            logic [7:0] im;
            bit         hold;
            op   = 3'($urandom_range(0, 7));
            a    = 2'($urandom_range(0, 3));
            b    = 2'($urandom_range(0, 3));
            d    = 2'($urandom_range(0, 3));
            im   = 8'($urandom);
            hold = 1'($urandom_range(0, 1));
            issue(op, a, b, d, im, hold, $sformatf("rnd%0d", i));
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        instr_valid = 1'b0;
        chained = 1'b0;
        drain("rnd");

        for (int i = 0; i < 4; i++) begin
            check($sformatf("final_r%0d", i), 32'(rf[i]), 32'(m_rf[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
